// File: rtl/unidade_controle.sv
// unidade_controle: Moore control FSM for the sequence-memory game.
// Define TIMEOUT_EN to enable the play timeout (conta_timer / fim_timer / fim_timeout).
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fim_sequencia,
  input  logic       ultima_sequencia,
  input  logic       fim_timer,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zera_timer,
  output logic       conta_timer,
  output logic       sel_nivel,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL           = 4'h0,
    PREPARACAO        = 4'h1,
    INICIA_SEQUENCIA  = 4'h2,
    ESPERA_JOGADA     = 4'h3,
    REGISTRA          = 4'h4,
    COMPARACAO        = 4'h5,
    PROXIMO           = 4'h6,
    PROXIMA_SEQUENCIA = 4'h7,
    FIM_ACERTOU       = 4'hA,
    FIM_TIMEOUT       = 4'hD,
    FIM_ERROU         = 4'hE
  } estado_t;

  estado_t estado_q, estado_d;
  logic    sel_nivel_q, sel_nivel_d;

`ifndef TIMEOUT_EN
  logic unused_fim_timer;
  assign unused_fim_timer = fim_timer;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      sel_nivel_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      sel_nivel_q <= sel_nivel_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    sel_nivel_d = sel_nivel_q;
    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARACAO;
      PREPARACAO: begin
        sel_nivel_d = nivel;
        estado_d    = INICIA_SEQUENCIA;
      end
      INICIA_SEQUENCIA: estado_d = ESPERA_JOGADA;
      // A play arriving with the timer terminal still counts as a play
      ESPERA_JOGADA: begin
        if (jogada_feita) estado_d = REGISTRA;
`ifdef TIMEOUT_EN
        else if (fim_timer) estado_d = FIM_TIMEOUT;
`endif
      end
      REGISTRA: estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                 estado_d = FIM_ERROU;
        else if (!fim_sequencia)    estado_d = PROXIMO;
        else if (ultima_sequencia)  estado_d = FIM_ACERTOU;
        else                        estado_d = PROXIMA_SEQUENCIA;
      end
      PROXIMO:           estado_d = ESPERA_JOGADA;
      PROXIMA_SEQUENCIA: estado_d = INICIA_SEQUENCIA;
      FIM_ACERTOU, FIM_ERROU: if (iniciar) estado_d = PREPARACAO;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
`endif
      default: estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraE       = 1'b0;
    contaE      = 1'b0;
    zeraL       = 1'b0;
    contaL      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    zera_timer  = 1'b0;
    conta_timer = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        zeraE      = 1'b1;
        zeraL      = 1'b1;
        zeraR      = 1'b1;
        zera_timer = 1'b1;
      end
      INICIA_SEQUENCIA: begin
        zeraE      = 1'b1;
        zera_timer = 1'b1;
      end
`ifdef TIMEOUT_EN
      ESPERA_JOGADA: conta_timer = 1'b1;
`endif
      REGISTRA: begin
        registraR  = 1'b1;
        zera_timer = 1'b1;
      end
      PROXIMO:           contaE = 1'b1;
      PROXIMA_SEQUENCIA: contaL = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign sel_nivel = sel_nivel_q;
  assign db_estado = estado_q;

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The module SHALL have port clock, input, 1 bit: single system clock, all state changes on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 forces the reset state immediately.
REQ-003 The module SHALL have inputs iniciar, nivel, jogada_feita, igual, fim_sequencia, ultima_sequencia and fim_timer, each 1 bit:
- iniciar: start pulse.
- nivel: level select, sampled at game start.
- jogada_feita: one-cycle pulse when a play is made.
- igual: stored play equals the memory word.
- fim_sequencia: address equals limit.
- ultima_sequencia: current limit is the last one for the level.
- fim_timer: timeout counter terminal.
REQ-004 The module SHALL have datapath control outputs, each 1 bit: zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer, conta_timer and sel_nivel.
REQ-005 The module SHALL have status outputs pronto, acertou, errou and timeout, each 1 bit, plus db_estado, 4 bits, giving the state code.

Function
REQ-006 The module SHALL implement a Moore FSM whose outputs decode only from the state register (sel_nivel from its own register), with state codes:
- inicial=0, preparacao=1, inicia_sequencia=2, espera_jogada=3
- registra=4, comparacao=5, proximo=6, proxima_sequencia=7
- fim_acertou=A, fim_timeout=D, fim_errou=E
- every unused code SHALL return to inicial next cycle.
REQ-007 The inicial state SHALL go to preparacao when iniciar=1, and hold otherwise.
REQ-008 The preparacao state SHALL assert zeraE, zeraL, zeraR and zera_timer, load sel_nivel<=nivel, and go to inicia_sequencia.
REQ-009 The inicia_sequencia state SHALL assert zeraE and zera_timer, and go to espera_jogada.
REQ-010 The espera_jogada state SHALL assert conta_timer and apply these transitions:
- jogada_feita=1 -> registra.
- else fim_timer=1 -> fim_timeout.
- else hold.
- jogada_feita SHALL win over a simultaneous fim_timer.
REQ-011 The registra state SHALL assert registraR and zera_timer, and go to comparacao; the comparison SHALL be evaluated one cycle after the register load.
REQ-012 The comparacao state SHALL assert no control outputs and apply these transitions, checked in order:
- igual=0 -> fim_errou.
- igual=1, fim_sequencia=0 -> proximo.
- igual=1, fim_sequencia=1, ultima_sequencia=1 -> fim_acertou.
- otherwise -> proxima_sequencia.
REQ-013 The proximo state SHALL assert contaE for exactly one cycle, and go to espera_jogada.
REQ-014 The proxima_sequencia state SHALL assert contaL for exactly one cycle, and go to inicia_sequencia.
REQ-015 Terminal states SHALL assert pronto plus exactly one of acertou, errou or timeout, hold while iniciar=0, and go to preparacao when iniciar=1.
REQ-016 All control and status outputs not listed for a state SHALL be 0.
REQ-017 Each control output SHALL be single-cycle per state visit, so contaE/contaL never double-count.
REQ-018 The sel_nivel output SHALL change only in preparacao or on reset; nivel changes mid-game SHALL be ignored.
REQ-019 An iniciar pulse outside inicial and the terminal states SHALL be ignored.

Reset
REQ-020 While reset=0:
- state SHALL be inicial.
- sel_nivel SHALL be 0.
- all outputs SHALL be 0.
- db_estado SHALL be 0.
REQ-021 Reset asserted mid-game SHALL abort immediately, with no further control pulses.
REQ-022 After reset deasserts, the first transition SHALL occur on the next rising edge per REQ-007.

Configuration
REQ-023 Macro TIMEOUT_EN defined: behaviour SHALL be per REQ-010, with the fim_timeout state reachable.
REQ-024 Macro TIMEOUT_EN undefined:
- conta_timer SHALL be tied 0.
- fim_timer SHALL be ignored.
- timeout SHALL be constant 0.
- fim_timeout SHALL be unreachable, with code D treated as unused per REQ-006.

Verification
REQ-025 Reset low mid-espera_jogada -> db_estado=0 asynchronously, all outputs 0, sel_nivel=0.
REQ-026 nivel=1, iniciar pulse, correct plays for limits 0..15 -> the following hold:
- db_estado visits 1,2,3,4,5,...
- contaL pulses 15 times.
- ends in A with pronto=1, acertou=1.
REQ-027 Start, then on second play igual=0 in comparacao -> db_estado=E, pronto=1, errou=1, contaE pulsed exactly once.
REQ-028 TIMEOUT_EN defined, no play, fim_timer=1 at cycle 5000 -> db_estado=D, timeout=1; with jogada_feita=1 on the same cycle -> db_estado=4 instead.
REQ-029 TIMEOUT_EN undefined, fim_timer=1 held in espera_jogada -> state stays 3, conta_timer=0, timeout=0.
REQ-030 In fim_errou, nivel=0 then iniciar pulse -> preparacao, sel_nivel=0, zeraE/zeraL/zeraR/zera_timer high one cycle, then state 2.
